// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int MEM_AW = 6;
  localparam int DATA_W = 32;
  localparam int NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way pick: round-robin on ties, or port 0 wins when fixed_prio is set.
module dmem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic fixed_prio,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = fixed_prio ? 1'b0 : ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// One access per three cycles: IDLE (arbitrate) -> ACCESS (strobe) -> DONE (ack).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [MEM_AW-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [MEM_AW-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [MEM_AW-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state_reg, state_next;

  logic [NPORTS-1:0] req_vec, we_vec, ack_vec, err_vec;
  logic [MEM_AW-1:0] addr_vec  [NPORTS];
  logic [DATA_W-1:0] wdata_vec [NPORTS];
  logic [DATA_W-1:0] rdata_vec [NPORTS];

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;

  logic grant_valid, grant_idx;
  logic last_grant_reg, gidx_reg;
  logic [MEM_AW-1:0] mem_address_reg;
  logic [DATA_W-1:0] mem_data_in_reg;
  logic mem_read_reg, mem_write_reg;

  dmem_rr_pick u_pick (
    .req0        (req_vec[0]),
    .req1        (req_vec[1]),
    .last_grant  (last_grant_reg),
    .fixed_prio  (FIXED_PRIO != 0),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Any low address bit set (this also catches 61..63, which would wrap) skips the memory.
  logic sel_misaligned;
  assign sel_misaligned = (addr_vec[grant_idx][1:0] != 2'b00);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = sel_misaligned ? DONE : ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Completion info for the port being acked at the edge into DONE.
  logic              done_idx, done_err;
  logic [DATA_W-1:0] done_rdata;
  assign done_idx   = (state_reg == IDLE) ? grant_idx : gidx_reg;
  assign done_err   = (state_reg == IDLE);
  assign done_rdata = (state_reg == ACCESS && mem_read_reg) ? mem_data_out : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      gidx_reg        <= 1'b0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_valid) begin
        last_grant_reg <= grant_idx;
        gidx_reg       <= grant_idx;
      end
      // The mem_* registers double as the latched request; they hold only during ACCESS.
      if (state_reg == IDLE && state_next == ACCESS) begin
        mem_address_reg <= addr_vec[grant_idx];
        mem_data_in_reg <= wdata_vec[grant_idx];
        mem_read_reg    <= ~we_vec[grant_idx];
        mem_write_reg   <= we_vec[grant_idx];
      end else begin
        mem_address_reg <= '0;
        mem_data_in_reg <= '0;
        mem_read_reg    <= 1'b0;
        mem_write_reg   <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      logic              ack_reg, err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
          if (state_next == DONE && done_idx == 1'(gi)) begin
            ack_reg   <= 1'b1;
            err_reg   <= done_err;
            rdata_reg <= done_rdata;
          end
        end
      end

      assign ack_vec[gi]   = ack_reg;
      assign err_vec[gi]   = err_reg;
      assign rdata_vec[gi] = rdata_reg;
    end
  endgenerate

  assign m0_ack       = ack_vec[0];
  assign m1_ack       = ack_vec[1];
  assign m0_err       = err_vec[0];
  assign m1_err       = err_vec[1];
  assign m0_rdata     = rdata_vec[0];
  assign m1_rdata     = rdata_vec[1];
  assign mem_address  = mem_address_reg;
  assign mem_data_in  = mem_data_in_reg;
  assign mem_memRead  = mem_read_reg;
  assign mem_memWrite = mem_write_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus, each with its own memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [5:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;

  logic        m0_ack, m0_err, m1_ack, m1_err, mem_memRead, mem_memWrite;
  logic [31:0] m0_rdata, m1_rdata, mem_data_in, mem_data_out;
  logic [5:0]  mem_address;

  logic        p1_m0_ack, p1_m0_err, p1_m1_ack, p1_m1_err, p1_mem_memRead, p1_mem_memWrite;
  logic [31:0] p1_m0_rdata, p1_m1_rdata, p1_mem_data_in, p1_mem_data_out;
  logic [5:0]  p1_mem_address;

  dmem_arbiter #(.FIXED_PRIO(0)) dut0 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_data_out(mem_data_out)
  );

  dmem_arbiter #(.FIXED_PRIO(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(p1_m0_ack), .m0_err(p1_m0_err), .m0_rdata(p1_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(p1_m1_ack), .m1_err(p1_m1_err), .m1_rdata(p1_m1_rdata),
    .mem_address(p1_mem_address), .mem_data_in(p1_mem_data_in),
    .mem_memRead(p1_mem_memRead), .mem_memWrite(p1_mem_memWrite), .mem_data_out(p1_mem_data_out)
  );

  // Word memories: combinational read, write on the falling edge.
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] <= 32'hA500_0000 | 32'(i);
      mem1[i] <= 32'hA500_0000 | 32'(i);
    end
  end
  always @(negedge clk) begin
    if (mem_memWrite)    mem0[mem_address[5:2]]    <= mem_data_in;
    if (p1_mem_memWrite) mem1[p1_mem_address[5:2]] <= p1_mem_data_in;
  end
  assign mem_data_out    = mem0[mem_address[5:2]];
  assign p1_mem_data_out = mem1[p1_mem_address[5:2]];

  int wr_cnt = 0, rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_memWrite) wr_cnt <= wr_cnt + 1;
    if (mem_memRead)  rd_cnt <= rd_cnt + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge while dut0 is IDLE; returns at a falling edge with dut0 IDLE again.
  task automatic run_one(input string tag, input int p, input logic we, input logic [5:0] a,
                         input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                         input logic exp_err);
    int lat = 0;
    logic [31:0] rd = 0;
    logic er = 0;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if ((p == 0) ? m0_ack : m1_ack) begin
        lat = k;
        rd  = (p == 0) ? m0_rdata : m1_rdata;
        er  = (p == 0) ? m0_err : m1_err;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    m0_req = 0; m1_req = 0;
    @(negedge clk);
  endtask

  // Both ports read together on dut0; reports the cycle of each ack (0 if none).
  task automatic both_req(input logic [5:0] a0, input logic [5:0] a1, output int l0, output int l1,
                          output logic [31:0] r0, output logic [31:0] r1);
    l0 = 0; l1 = 0; r0 = 0; r1 = 0;
    m0_req = 1; m0_we = 0; m0_addr = a0;
    m1_req = 1; m1_we = 0; m1_addr = a1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m0_ack) begin l0 = k; r0 = m0_rdata; m0_req = 0; end
      if (m1_ack) begin l1 = k; r1 = m1_rdata; m1_req = 0; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0c, l0, l1, m0seen;
    logic [31:0] rd0, rd1, map0, map1;

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    chk("rst_m0_ack", 32'(m0_ack), 0);
    chk("rst_m1_err", 32'(m1_err), 0);
    chk("rst_mem_strobes", {30'b0, mem_memRead, mem_memWrite}, 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back on port 0
    w0 = wr_cnt; r0c = rd_cnt;
    run_one("wr8", 0, 1, 6'd8, 32'hDEADBEEF, 2, 32'h0, 0);
    run_one("rd8", 0, 0, 6'd8, 32'h0, 2, 32'hDEADBEEF, 0);
    chk("wr_strobe_cycles", 32'(wr_cnt - w0), 1);
    chk("rd_strobe_cycles", 32'(rd_cnt - r0c), 1);

    // Round-robin ties: after reset port 0 wins; after a port-0 grant port 1 wins
    do_reset();
    both_req(6'd8, 6'd12, l0, l1, rd0, rd1);
    chk("rr1_m0_lat", 32'(l0), 2);
    chk("rr1_m1_lat", 32'(l1), 5);
    chk("rr1_m0_rdata", rd0, 32'hDEADBEEF);
    chk("rr1_m1_rdata", rd1, 32'hA500_0003);
    run_one("rr_solo_m0", 0, 0, 6'd4, 32'h0, 2, 32'hA500_0001, 0);
    both_req(6'd8, 6'd12, l0, l1, rd0, rd1);
    chk("rr2_m1_lat", 32'(l1), 2);
    chk("rr2_m0_lat", 32'(l0), 5);

    // Misaligned address near the top: error ack after one cycle, no strobes
    w0 = wr_cnt; r0c = rd_cnt;
    run_one("mis62", 1, 0, 6'd62, 32'h0, 1, 32'h0, 1);
    chk("mis_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0c)), 0);
    chk("mis_m0_ack_quiet", 32'(m0_ack), 0);

    // Request inputs change while waiting and while in ACCESS
    m1_req = 1; m1_we = 0; m1_addr = 6'd24;
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 6'd28; m0_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("chg_m1_ack", 32'(m1_ack), 1);
    chk("chg_m1_rdata", m1_rdata, 32'hA500_0006);
    chk("chg_m0_wait_ack", 32'(m0_ack), 0);
    m1_req = 0; m0_addr = 6'd32; m0_wdata = 32'h2222_2222;
    @(negedge clk);
    @(negedge clk);
    chk("chg_mem_addr", 32'(mem_address), 32);
    chk("chg_mem_wdata", mem_data_in, 32'h2222_2222);
    chk("chg_mem_we", 32'(mem_memWrite), 1);
    m0_addr = 6'd36; m0_wdata = 32'h3333_3333;
    @(negedge clk);
    chk("chg_m0_ack", 32'(m0_ack), 1);
    m0_req = 0;
    @(negedge clk);
    run_one("chg_rd32", 0, 0, 6'd32, 32'h0, 2, 32'h2222_2222, 0);
    run_one("chg_rd36", 0, 0, 6'd36, 32'h0, 2, 32'hA500_0009, 0);
    run_one("chg_rd28", 0, 0, 6'd28, 32'h0, 2, 32'hA500_0007, 0);

    // Reset in the middle of an m0 write with m1 pending
    m0_req = 1; m0_we = 1; m0_addr = 6'd16; m0_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("abort_pre_we", 32'(mem_memWrite), 1);
    m1_req = 1; m1_we = 0; m1_addr = 6'd20;
    #2 reset = 1'b1;
    #1;
    chk("abort_async_we", 32'(mem_memWrite), 0);
    m0_req = 0;
    @(negedge clk);
    chk("abort_m0_ack", 32'(m0_ack), 0);
    chk("abort_m0_rdata", m0_rdata, 0);
    reset = 1'b0;
    l1 = 0; m0seen = 0;
    for (int k = 1; k <= 6 && l1 == 0; k++) begin
      @(negedge clk);
      if (m0_ack) m0seen = 1;
      if (m1_ack) begin l1 = k; rd1 = m1_rdata; end
    end
    chk("abort_m1_lat", 32'(l1), 2);
    chk("abort_m1_rdata", rd1, 32'hA500_0005);
    chk("abort_no_m0_ack", 32'(m0seen), 0);
    m1_req = 0;
    @(negedge clk);

    // Fixed priority: port 0 holds its request, port 1 starves until it drops
    do_reset();
    map0 = 0; map1 = 0; rd0 = 0; rd1 = 0;
    m0_req = 1; m0_we = 0; m0_addr = 6'd8;
    m1_req = 1; m1_we = 0; m1_addr = 6'd12;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (p1_m0_ack) begin map0 = map0 | (32'd1 << k); rd0 = p1_m0_rdata; end
      if (p1_m1_ack) begin map1 = map1 | (32'd1 << k); rd1 = p1_m1_rdata; m1_req = 0; end
      if (k == 8) m0_req = 0;
    end
    chk("fp_m0_ack_map", map0, 32'h0000_0124);
    chk("fp_m1_ack_map", map1, 32'h0000_0800);
    chk("fp_m0_rdata", rd0, 32'hDEADBEEF);
    chk("fp_m1_rdata", rd1, 32'hA500_0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
